// File: rtl/ic_miss_handler_pkg.sv
// Shared types and helpers for the icache miss handler.
package ic_miss_handler_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAlloc,
    StWait,
    StWrite
  } ic_miss_state_t;

  function automatic int unsigned ic_offset_width(input int unsigned line_size);
    return $clog2(line_size);
  endfunction

  // Clears the byte-offset bits; callers zero-extend narrower addresses to 64 bits.
  function automatic logic [63:0] ic_line_align(input logic [63:0] addr,
                                               input int unsigned offset_width);
    return (addr >> offset_width) << offset_width;
  endfunction

endpackage

// File: rtl/ic_miss_handler.sv
// Instruction-cache miss controller: stalls fetch, allocates one line in the IFQ,
// waits for its fill, writes the icache and pulses a replay.
module ic_miss_handler
  import ic_miss_handler_pkg::*;
#(
  parameter int unsigned OPTN_ADDR_WIDTH     = 32,
  parameter int unsigned OPTN_IC_LINE_SIZE   = 32,
  parameter int unsigned OPTN_MISS_CNT_WIDTH = 16,
  parameter int unsigned IC_LINE_WIDTH       = OPTN_IC_LINE_SIZE * 8
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           i_redirect,
  input  logic                           i_lookup_valid,
  input  logic [OPTN_ADDR_WIDTH-1:0]     i_lookup_addr,
  input  logic                           i_lookup_hit,
  output logic                           o_stall,
  input  logic                           i_ifq_full,
  output logic                           o_alloc_en,
  output logic [OPTN_ADDR_WIDTH-1:0]     o_alloc_addr,
  input  logic                           i_fill_en,
  input  logic [OPTN_ADDR_WIDTH-1:0]     i_fill_addr,
  input  logic [IC_LINE_WIDTH-1:0]       i_fill_data,
  output logic                           o_ic_wr_en,
  output logic [OPTN_ADDR_WIDTH-1:0]     o_ic_wr_addr,
  output logic [IC_LINE_WIDTH-1:0]       o_ic_wr_data,
  output logic                           o_replay,
  output logic [OPTN_MISS_CNT_WIDTH-1:0] o_miss_count
);

  localparam int unsigned OffW = ic_offset_width(OPTN_IC_LINE_SIZE);

  ic_miss_state_t                 state_q, state_d;
  logic                           squash_q, squash_d;
  logic [OPTN_ADDR_WIDTH-1:0]     miss_addr_q, miss_addr_d;
  logic [IC_LINE_WIDTH-1:0]       line_q, line_d;
  logic [OPTN_MISS_CNT_WIDTH-1:0] miss_count_q, miss_count_d;

  logic        idle_miss;
  logic        fill_match;
  logic        alloc_issue;
  logic [63:0] lookup_aligned;

  assign lookup_aligned = ic_line_align(64'(i_lookup_addr), OffW);
  assign idle_miss   = (state_q == StIdle) & i_lookup_valid & ~i_lookup_hit & ~i_redirect;
  assign fill_match  = i_fill_en &
                       (i_fill_addr[OPTN_ADDR_WIDTH-1:OffW] == miss_addr_q[OPTN_ADDR_WIDTH-1:OffW]);
  assign alloc_issue = (state_q == StAlloc) & ~i_redirect & ~i_ifq_full;

  logic unused_fill_offset;
  assign unused_fill_offset = ^i_fill_addr[OffW-1:0];

  if (OPTN_ADDR_WIDTH < 64) begin : g_unused_align_hi
    logic unused_align_hi;
    assign unused_align_hi = ^lookup_aligned[63:OPTN_ADDR_WIDTH];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= StIdle;
      squash_q     <= 1'b0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      squash_q     <= squash_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Address and line data need no reset: only read while a miss is live.
  always_ff @(posedge clk) begin
    miss_addr_q <= miss_addr_d;
    line_q      <= line_d;
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    squash_d     = squash_q;
    miss_addr_d  = miss_addr_q;
    line_d       = line_q;
    miss_count_d = miss_count_q;

    unique case (state_q)
      StIdle: begin
        if (idle_miss) begin
          miss_addr_d = lookup_aligned[OPTN_ADDR_WIDTH-1:0];
          state_d     = StAlloc;
        end
      end
      StAlloc: begin
        if (i_redirect) begin
          state_d = StIdle;
        end else if (!i_ifq_full) begin
          state_d = StWait;
        end
      end
      StWait: begin
        // The IFQ still returns the line after a redirect, so keep waiting but drop the replay.
        if (i_redirect) begin
          squash_d = 1'b1;
        end
        if (fill_match) begin
          line_d  = i_fill_data;
          state_d = StWrite;
        end
      end
      StWrite: begin
        squash_d = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (alloc_issue && (miss_count_q != '1)) begin
      miss_count_d = miss_count_q + OPTN_MISS_CNT_WIDTH'(1);
    end
  end

  // Outputs
  always_comb begin
    o_stall      = (state_q != StIdle) | idle_miss;
    o_alloc_en   = alloc_issue;
    o_alloc_addr = miss_addr_q;
    o_ic_wr_en   = (state_q == StWrite);
    o_ic_wr_addr = miss_addr_q;
    o_ic_wr_data = line_q;
    o_replay     = (state_q == StWrite) & ~squash_q & ~i_redirect;
    o_miss_count = miss_count_q;
  end

endmodule

// File: tb/tb_ic_miss_handler.sv
// Scoreboard bench for ic_miss_handler: driver pushes expected allocations and
// line writes, a negedge monitor pops and compares them as the DUT emits them.
module tb_ic_miss_handler;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          i_redirect;
  logic          i_lookup_valid;
  logic [AW-1:0] i_lookup_addr;
  logic          i_lookup_hit;
  logic          o_stall;
  logic          i_ifq_full;
  logic          o_alloc_en;
  logic [AW-1:0] o_alloc_addr;
  logic          i_fill_en;
  logic [AW-1:0] i_fill_addr;
  logic [LW-1:0] i_fill_data;
  logic          o_ic_wr_en;
  logic [AW-1:0] o_ic_wr_addr;
  logic [LW-1:0] o_ic_wr_data;
  logic          o_replay;
  logic [CW-1:0] o_miss_count;

  ic_miss_handler #(
    .OPTN_ADDR_WIDTH    (AW),
    .OPTN_IC_LINE_SIZE  (32),
    .OPTN_MISS_CNT_WIDTH(CW)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .i_redirect    (i_redirect),
    .i_lookup_valid(i_lookup_valid),
    .i_lookup_addr (i_lookup_addr),
    .i_lookup_hit  (i_lookup_hit),
    .o_stall       (o_stall),
    .i_ifq_full    (i_ifq_full),
    .o_alloc_en    (o_alloc_en),
    .o_alloc_addr  (o_alloc_addr),
    .i_fill_en     (i_fill_en),
    .i_fill_addr   (i_fill_addr),
    .i_fill_data   (i_fill_data),
    .o_ic_wr_en    (o_ic_wr_en),
    .o_ic_wr_addr  (o_ic_wr_addr),
    .o_ic_wr_data  (o_ic_wr_data),
    .o_replay      (o_replay),
    .o_miss_count  (o_miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
    logic          replay;
  } wr_exp_t;

  logic [AW-1:0] alloc_q[$];
  wr_exp_t       wr_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            exp_count = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every DUT allocation and line write must match the next expectation.
  always @(negedge clk) begin
    if (n_rst) begin
      if (o_alloc_en) begin
        if (alloc_q.size() == 0) check("unexpected_alloc", o_alloc_addr, '1);
        else check("alloc_addr", o_alloc_addr, alloc_q.pop_front());
      end
      if (o_ic_wr_en) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", o_ic_wr_addr, '1);
        end else begin
          wr_exp_t e;
          e = wr_q.pop_front();
          check("wr_addr", o_ic_wr_addr, e.addr);
          check("wr_data", o_ic_wr_data, e.data);
          check("replay", o_replay, e.replay);
        end
      end else if (o_replay) begin
        check("replay_without_write", o_replay, 1'b0);
      end
    end
  end

  task automatic tick(input logic exp_stall);
    @(negedge clk);
    check("stall", o_stall, exp_stall);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_redirect = 0; i_lookup_valid = 0; i_lookup_hit = 0; i_ifq_full = 0; i_fill_en = 0;
  endtask

  task automatic junk_lookup();
    i_lookup_valid = 1'($urandom_range(0, 1));
    i_lookup_hit   = 1'($urandom_range(0, 1));
    i_lookup_addr  = $urandom;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic do_miss(input logic [AW-1:0] addr, input logic [LW-1:0] data, input int n_full,
                         input bit redir_alloc, input int n_wait, input bit foreign,
                         input int redir_wait_at, input bit redir_fill, input bit redir_write);
    logic [AW-1:0] line;
    bit squashed;
    wr_exp_t e;
    line = (addr / 32) * 32;
    squashed = 0;
    i_lookup_valid = 1; i_lookup_hit = 0; i_lookup_addr = addr; i_ifq_full = (n_full > 0);
    tick(1);
    for (int k = 0; k < n_full; k++) begin
      i_ifq_full = 1; junk_lookup();
      tick(1);
    end
    if (redir_alloc) begin
      i_redirect = 1; i_ifq_full = 1'($urandom_range(0, 1)); junk_lookup();
      tick(1);
      idle_inputs();
      tick(0);
      check("count_after_redirect", o_miss_count, exp_count[CW-1:0]);
      return;
    end
    i_ifq_full = 0; junk_lookup();
    alloc_q.push_back(line);
    if (exp_count < (1 << CW) - 1) exp_count++;
    tick(1);
    for (int k = 0; k < n_wait; k++) begin
      i_redirect = (k == redir_wait_at);
      if (k == redir_wait_at) squashed = 1;
      i_fill_en   = foreign ? 1'b1 : 1'($urandom_range(0, 1));
      i_fill_addr = line ^ (32'h20 << $urandom_range(0, 26));
      i_fill_data = rand_line();
      i_ifq_full  = 1'($urandom_range(0, 1));
      junk_lookup();
      tick(1);
    end
    i_redirect = redir_fill;
    if (redir_fill) squashed = 1;
    i_fill_en = 1; i_fill_addr = line; i_fill_data = data; junk_lookup();
    e.addr = line; e.data = data; e.replay = !squashed && !redir_write;
    wr_q.push_back(e);
    tick(1);
    i_redirect = redir_write; i_fill_en = 1'($urandom_range(0, 1)); i_fill_addr = line;
    i_fill_data = rand_line(); i_lookup_valid = 0;
    tick(1);
    idle_inputs();
    tick(0);
    check("miss_count", o_miss_count, exp_count[CW-1:0]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [LW-1:0] a5;
    a5 = {32{8'hA5}};
    n_rst = 0; i_lookup_addr = '0; i_fill_addr = '0; i_fill_data = '0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 n_rst = 1;
    @(negedge clk);
    check("rst_alloc_en", o_alloc_en, 1'b0);
    check("rst_wr_en", o_ic_wr_en, 1'b0);
    check("rst_replay", o_replay, 1'b0);
    check("rst_count", o_miss_count, '0);
    @(posedge clk); #1;
    tick(0);

    // Directed cases
    do_miss(32'h1004, a5, 0, 0, 0, 0, -1, 0, 0);
    do_miss(32'h2010, rand_line(), 3, 0, 1, 0, -1, 0, 0);
    do_miss(32'h3000, rand_line(), 0, 0, 3, 1, -1, 0, 0);
    do_miss(32'h3808, rand_line(), 2, 1, 0, 0, -1, 0, 0);
    do_miss(32'h5000, rand_line(), 0, 0, 2, 0, 0, 0, 0);
    do_miss(32'h5440, rand_line(), 0, 0, 0, 0, -1, 1, 0);
    do_miss(32'h5880, rand_line(), 0, 0, 1, 0, -1, 0, 1);

    // Redirect and hit in IDLE never stall or allocate
    i_lookup_valid = 1; i_lookup_hit = 0; i_lookup_addr = 32'h7000; i_redirect = 1;
    tick(0);
    i_redirect = 0; i_lookup_hit = 1;
    tick(0);
    idle_inputs();

    // Reset while waiting for a fill abandons the miss
    i_lookup_valid = 1; i_lookup_addr = 32'h6004;
    tick(1);
    i_lookup_valid = 0;
    alloc_q.push_back(32'h6000);
    tick(1);
    n_rst = 0;
    @(posedge clk); #1;
    n_rst = 1; exp_count = 0;
    @(negedge clk);
    check("mid_rst_alloc_en", o_alloc_en, 1'b0);
    check("mid_rst_wr_en", o_ic_wr_en, 1'b0);
    check("mid_rst_replay", o_replay, 1'b0);
    check("mid_rst_count", o_miss_count, '0);
    @(posedge clk); #1;
    i_fill_en = 1; i_fill_addr = 32'h6000; i_fill_data = rand_line();
    tick(0);
    i_fill_en = 0;
    tick(0);
    i_lookup_valid = 1; i_lookup_hit = 1; i_lookup_addr = 32'h6000;
    tick(0);
    idle_inputs();
    tick(0);

    // Randomized misses
    for (int n = 0; n < 150; n++) begin
      int rw;
      rw = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 3)) : -1;
      do_miss($urandom, rand_line(), $urandom_range(0, 3), $urandom_range(0, 5) == 0,
              $urandom_range(0, 4), $urandom_range(0, 1), rw,
              $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 2) == 0) tick(0);
    end

    repeat (3) tick(0);
    check("alloc_queue_drained", 256'(alloc_q.size()), '0);
    check("write_queue_drained", 256'(wr_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ic_miss_handler.md
Name: ic_miss_handler

Overview:
- Instruction-cache miss controller between the fetch/icache lookup stage and the instruction fetch queue (IFQ).
- On a lookup miss it stalls fetch and issues one line-aligned allocation to the IFQ.
- It waits for the matching fill, writes the line into the icache, then pulses a replay so fetch re-looks-up.
- One outstanding miss at a time.

Parameters:
- OPTN_ADDR_WIDTH, 32, byte address width.
- OPTN_IC_LINE_SIZE, 32, icache line size in bytes; power of two.
- OPTN_MISS_CNT_WIDTH, 16, width of the saturating miss counter.
- IC_LINE_WIDTH, OPTN_IC_LINE_SIZE*8, line data width (derived).

Ports:
- clk  in  1  clock
- n_rst  in  1  synchronous active-low reset
- i_redirect  in  1  fetch redirect/flush; squashes the current miss
- i_lookup_valid  in  1  icache lookup result valid this cycle
- i_lookup_addr  in  OPTN_ADDR_WIDTH  fetch address looked up
- i_lookup_hit  in  1  tag hit for i_lookup_addr
- o_stall  out  1  fetch must hold its PC
- i_ifq_full  in  1  IFQ cannot accept an allocation
- o_alloc_en  out  1  allocation request to IFQ
- o_alloc_addr  out  OPTN_ADDR_WIDTH  line-aligned miss address
- i_fill_en  in  1  IFQ fill valid
- i_fill_addr  in  OPTN_ADDR_WIDTH  line-aligned fill address
- i_fill_data  in  IC_LINE_WIDTH  fill line data
- o_ic_wr_en  out  1  icache line write enable
- o_ic_wr_addr  out  OPTN_ADDR_WIDTH  line-aligned write address
- o_ic_wr_data  out  IC_LINE_WIDTH  line data to write
- o_replay  out  1  one-cycle pulse: fetch re-issues lookup
- o_miss_count  out  OPTN_MISS_CNT_WIDTH  allocations issued, saturating

Behaviour:
- Reset: n_rst is synchronous and active-low; clock is clk. On reset, state=IDLE and squash=0. o_alloc_en, o_ic_wr_en, o_replay and o_miss_count are 0. Address and data registers are don't-care. Reset mid-miss abandons the miss, and any later fill is ignored in IDLE.
- States: IDLE, ALLOC, WAIT, WRITE.
- IDLE:
  - Miss condition is i_lookup_valid & ~i_lookup_hit & ~i_redirect.
  - On a miss, capture miss_addr = i_lookup_addr with the offset bits zeroed, then go to ALLOC.
  - o_stall is combinationally 1 on the miss cycle, so fetch never advances past a miss.
- ALLOC:
  - o_alloc_en = ~i_ifq_full (combinational); o_alloc_addr = miss_addr.
  - If i_redirect=1: go to IDLE and suppress o_alloc_en this cycle. Redirect has priority over issue.
  - Else if ~i_ifq_full: allocation issued, increment o_miss_count (saturate at all-ones), go to WAIT.
  - Else stay in ALLOC.
- WAIT:
  - Match when i_fill_en=1 and i_fill_addr[ADDR-1:OFFSET] == miss_addr[ADDR-1:OFFSET]. On a match, latch i_fill_data and go to WRITE.
  - Non-matching fills are ignored.
  - i_redirect in WAIT sets squash=1. The miss keeps waiting, because the IFQ will still return the line.
  - Redirect coincident with the matching fill: latch the data, set squash, go to WRITE.
- WRITE (exactly 1 cycle):
  - o_ic_wr_en=1, o_ic_wr_addr=miss_addr, o_ic_wr_data=latched line.
  - o_replay = ~squash & ~i_redirect.
  - Clear squash, go to IDLE.
- o_stall = (state != IDLE) | IDLE miss condition. It is released in the cycle after WRITE.
- Lookups are ignored in every state except IDLE.
- Latency: a miss in cycle N gives o_alloc_en in N+1 (if not full). A fill in cycle M gives o_ic_wr_en and o_replay in M+1.
- Offset width = $clog2(OPTN_IC_LINE_SIZE). Address compare and alignment are both done on bits [ADDR-1:offset].

Decomposition:
- Shared package:
  - ic_miss_state_t enum (IDLE, ALLOC, WAIT, WRITE).
  - IC_OFFSET_WIDTH constant function.
  - Line-align helper function.
- No sub-module. The saturating counter is inline; an FSM plus registers comes to roughly 150-200 lines.

Test Plan (ADDR=32, LINE=32, offset width 5):
- Basic miss:
  - Stimulus: lookup miss at 0x1004, IFQ not full.
  - Response: o_alloc_en=1 with addr 0x1000 next cycle. A fill of 0x1000 with data 0xA5..A5 gives o_ic_wr_en=1, addr 0x1000, that data, and o_replay=1 one cycle later. o_stall=1 throughout, then 0. o_miss_count=1.
- Back-pressure:
  - Stimulus: miss at 0x2010 while i_ifq_full=1 for 3 cycles.
  - Response: o_alloc_en=0 for 3 cycles, then exactly one alloc of 0x2000 on the 4th cycle. o_miss_count increments once.
- Foreign fill:
  - Stimulus: in WAIT for 0x3000, fill 0x4000 arrives.
  - Response: ignored, no write. A later fill of 0x3000 is written.
- Redirect in ALLOC:
  - Stimulus: i_redirect=1 with i_ifq_full=1.
  - Response: no alloc ever issued, back to IDLE, o_stall=0 next cycle, o_miss_count unchanged.
- Redirect in WAIT:
  - Stimulus: miss 0x5000, redirect 2 cycles later, fill 0x5000 afterwards.
  - Response: o_ic_wr_en=1 for 0x5000, o_replay=0.
- Reset mid-miss:
  - Stimulus: n_rst=0 in WAIT, then fill 0x6000.
  - Response: all outputs 0 after reset, no write, counter 0. A hit lookup never asserts o_stall.
